// File: rtl/ffd_bank_pkg.sv
// ffd_bank_pkg: op encoding, command and FSM state types for ffd_bank_ctrl
package ffd_bank_pkg;
  localparam logic [1:0] ENC_NOP = 2'b00;
  localparam logic [1:0] ENC_LOAD = 2'b01;
  localparam logic [1:0] ENC_CLEAR = 2'b10;
  localparam logic [1:0] ENC_PRESET = 2'b11;
  typedef enum logic [1:0] {
    NOP = ENC_NOP,
    LOAD = ENC_LOAD,
    CLEAR = ENC_CLEAR,
    PRESET = ENC_PRESET
  } op_t;
  typedef enum logic [2:0] {IDLE, DRIVE, PULSE, SETTLE, VERIFY, DONE} state_t;
endpackage

// File: rtl/ffd_bank_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin, the requester other than last_grant wins on contention
module rr_arbiter2 (
  input logic [1:0] valid,
  input logic last_grant,
  input logic en,
  output logic [1:0] grant,
  output logic winner
);
  assign winner = &valid ? !last_grant : valid[1];
  assign grant = en ? {valid[1] & winner, valid[0] & !winner} : 2'b00;
endmodule

// File: rtl/ffd_bank_ctrl.sv
// ffd_bank_ctrl: arbitrated LOAD/CLEAR/PRESET sequencer for a negedge preset/clear FF bank; READBACK_CHECK_EN adds VERIFY and err
module ffd_bank_ctrl
  import ffd_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PULSE_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  input logic [1:0] req_valid,
  input logic [3:0] req_op,
  input logic [2*WIDTH-1:0] req_data,
  output logic [1:0] req_ready,
  output logic [WIDTH-1:0] bank_d,
  output logic bank_preset_n,
  output logic bank_clear_n,
  input logic [WIDTH-1:0] bank_q,
  output logic busy,
  output logic done,
  output logic grant_id
`ifdef READBACK_CHECK_EN
  ,
  output logic err
`endif
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);
`ifdef READBACK_CHECK_EN
  localparam state_t AFTER_SETTLE = VERIFY;
`else
  localparam state_t AFTER_SETTLE = DONE;
`endif
  state_t state, state_nx;
  op_t op, win_op;
  logic [WIDTH-1:0] shadow, win_data;
  logic [CW-1:0] cnt;
  logic [1:0] grant;
  logic last_grant, rst_q, winner, xfer;
  rr_arbiter2 u_arb (
    .valid(req_valid),
    .last_grant(last_grant),
    .en(state == IDLE && !reset),
    .grant(grant),
    .winner(winner)
  );
  assign xfer = |grant;
  assign win_op = op_t'(winner ? req_op[3:2] : req_op[1:0]);
  assign win_data = winner ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shadow <= '0;
      cnt <= '0;
      op <= NOP;
      grant_id <= 1'b0;
      last_grant <= 1'b1;
      rst_q <= 1'b1;
    end else begin
      state <= state_nx;
      rst_q <= 1'b0;
      cnt <= state == PULSE ? cnt + CW'(1) : '0;
      if (xfer) begin
        op <= win_op;
        grant_id <= winner;
        last_grant <= winner;
        if (win_op != NOP) shadow <= win_op == LOAD ? win_data : win_op == CLEAR ? '0 : '1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (xfer) state_nx = win_op == NOP ? DONE : win_op == LOAD ? DRIVE : PULSE;
      DRIVE: state_nx = SETTLE;
      PULSE: if (cnt == CW'(PULSE_CYCLES - 1)) state_nx = SETTLE;
      SETTLE: state_nx = AFTER_SETTLE;
      VERIFY: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = grant;
    bank_d = shadow;
    busy = state != IDLE;
    done = state == DONE;
    bank_preset_n = !(state == PULSE && op == PRESET);
    bank_clear_n = !(rst_q || (state == PULSE && op == CLEAR));
  end
`ifdef READBACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (state == VERIFY && bank_q != shadow) err <= 1'b1;
  end
`else
  logic unused_q;
  assign unused_q = ^bank_q;
`endif
endmodule

// File: tb/tb_ffd_bank_ctrl.sv
// tb_ffd_bank_ctrl: directed and random command streams against a negedge FF bank model and a spec-level reference
module tb_ffd_bank_ctrl;
  localparam int W = 8;
  localparam int P = 2;
`ifdef READBACK_CHECK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int LAT_LOAD = 3 + RB;
  localparam int LAT_PULSE = P + 2 + RB;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid = 2'b11;
  logic [3:0] req_op = 4'b0;
  logic [2*W-1:0] req_data = '0;
  logic [1:0] req_ready;
  logic [W-1:0] bank_d, bank_q, bank_ff;
  logic [W-1:0] stuck_mask = '1;
  logic bank_preset_n, bank_clear_n, busy, done, grant_id;
  int total = 0;
  int bad = 0;
  logic lg = 1'b1;
  logic [W-1:0] bank_exp = '0;
  logic err_exp = 1'b0;
`ifdef READBACK_CHECK_EN
  logic err;
`endif
  always #5 clk = ~clk;
  ffd_bank_ctrl #(.WIDTH(W), .PULSE_CYCLES(P)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_data(req_data),
    .req_ready(req_ready),
    .bank_d(bank_d),
    .bank_preset_n(bank_preset_n),
    .bank_clear_n(bank_clear_n),
    .bank_q(bank_q),
    .busy(busy),
    .done(done),
    .grant_id(grant_id)
`ifdef READBACK_CHECK_EN
    ,
    .err(err)
`endif
  );
  always @(negedge clk or negedge bank_preset_n or negedge bank_clear_n)
    if (!bank_clear_n) bank_ff <= '0;
    else if (!bank_preset_n) bank_ff <= '1;
    else bank_ff <= bank_d;
  assign bank_q = bank_ff & stuck_mask;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_err(input string tag);
`ifdef READBACK_CHECK_EN
    check(tag, err, err_exp);
`else
    check(tag, 32'(busy), 32'(1'b0));
`endif
  endtask
  task automatic run_cmd(input string tag);
    logic w, both_low, leak, gid_ok;
    logic [1:0] op;
    logic [W-1:0] d, val;
    int lat, cyc, pl, cl;
    w = &req_valid ? !lg : req_valid[1];
    op = w ? req_op[3:2] : req_op[1:0];
    d = w ? req_data[2*W-1:W] : req_data[W-1:0];
    lat = op == 2'd0 ? 1 : op == 2'd1 ? LAT_LOAD : LAT_PULSE;
    val = op == 2'd0 ? bank_exp : op == 2'd1 ? d : op == 2'd2 ? '0 : '1;
    #1;
    check({tag, "_ready"}, req_ready, w ? 2'b10 : 2'b01);
    tick;
    req_valid[w] = 1'b0;
    cyc = 1;
    pl = 0;
    cl = 0;
    both_low = 1'b0;
    leak = 1'b0;
    gid_ok = 1'b1;
    while (!done && cyc < 20) begin
      pl += int'(!bank_preset_n);
      cl += int'(!bank_clear_n);
      both_low |= !bank_preset_n && !bank_clear_n;
      leak |= req_ready != 2'b00;
      gid_ok &= grant_id == w && busy;
      tick;
      cyc++;
    end
    gid_ok &= grant_id == w && busy;
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_gid"}, gid_ok, 1);
    check({tag, "_preset_cyc"}, pl, op == 2'd3 ? P : 0);
    check({tag, "_clear_cyc"}, cl, op == 2'd2 ? P : 0);
    check({tag, "_both_low"}, both_low, 0);
    check({tag, "_ready_busy"}, leak, 0);
    bank_exp = val;
    lg = w;
    if (op != 2'd0 && (val & stuck_mask) != val) err_exp = 1'b1;
    check({tag, "_bank_q"}, bank_q, bank_exp & stuck_mask);
    check({tag, "_bank_d"}, bank_d, bank_exp);
    tick;
    check({tag, "_done_1cyc"}, {done, busy}, 2'b00);
    check({tag, "_bank_d_hold"}, bank_d, bank_exp);
    check_err({tag, "_err"});
  endtask
  task automatic do_reset;
    reset = 1'b1;
    req_valid = 2'b11;
    tick;
    tick;
    check("rst_clear_n", bank_clear_n, 0);
    check("rst_preset_n", bank_preset_n, 1);
    check("rst_ready", req_ready, 0);
    check("rst_busy_done", {busy, done, grant_id}, 0);
    req_valid = 2'b00;
    reset = 1'b0;
    lg = 1'b1;
    bank_exp = '0;
    err_exp = 1'b0;
    tick;
    check("rel_clear_n", bank_clear_n, 1);
    check("rel_bank_q", bank_q, 0);
    check("rel_bank_d", bank_d, 0);
    check("rel_busy", busy, 0);
    check_err("rel_err");
  endtask
  initial begin
    logic seen;
    do_reset();
    req_valid = 2'b01;
    req_op = 4'b0001;
    req_data = 16'h00A5;
    run_cmd("load_a5");
    req_valid = 2'b10;
    req_op = 4'b1100;
    run_cmd("preset_r1");
    req_valid = 2'b11;
    req_op = 4'b1001;
    req_data = 16'h003C;
    run_cmd("both_first");
    check("both_a_q", bank_q, 8'h3C);
    run_cmd("both_second");
    check("both_final_q", bank_q, 8'h00);
    req_valid = 2'b01;
    req_op = 4'b0000;
    run_cmd("nop");
    req_valid = 2'b01;
    req_op = 4'b0001;
    req_data = 16'h0077;
    run_cmd("load_77");
    req_valid = 2'b01;
    req_op = 4'b0010;
    #1;
    check("abort_ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    check("abort_in_pulse", {bank_clear_n, busy}, 2'b01);
    reset = 1'b1;
    tick;
    check("abort_idle", {busy, done, bank_preset_n}, 3'b001);
    check("abort_shadow", bank_d, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      seen |= done;
      tick;
    end
    check("abort_no_done", seen, 0);
    check("abort_bank_q", bank_q, 0);
    lg = 1'b1;
    bank_exp = '0;
    err_exp = 1'b0;
    stuck_mask = 8'hF7;
    req_valid = 2'b01;
    req_op = 4'b0001;
    req_data = 16'h00FF;
    run_cmd("stuck_load");
`ifdef READBACK_CHECK_EN
    check("stuck_err_set", err, 1);
`endif
    stuck_mask = '1;
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] && $urandom_range(0, 3) != 0) begin
          req_valid[r] = 1'b1;
          req_op[2*r+:2] = 2'($urandom);
          req_data[W*r+:W] = W'($urandom);
        end
      end
      if (req_valid == 2'b00) begin
        req_valid[0] = 1'b1;
        req_op[1:0] = 2'($urandom);
        req_data[W-1:0] = W'($urandom);
      end
      run_cmd("rnd");
    end
    while (req_valid != 2'b00) run_cmd("drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
